// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the register-file recovery sequencer.
// The sequencer steps through the register file RF_REC_RD_PORTS registers per backup cycle.
package cv32e40p_pkg;

    localparam int RF_REC_RD_PORTS = 3;
    localparam int RF_REC_WR_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE,
        BACKUP,
        RESTORE
    } rf_rec_state_e;

    function automatic int rf_rec_ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/cv32e40p_rf_recovery_shadow.sv
// Flop-based shadow copy of the register file: three write ports, two combinational read ports.
// Write addresses never collide within one cycle.
module cv32e40p_rf_recovery_shadow
    import cv32e40p_pkg::*;
#(
    parameter int NUM_REGS = 32,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          we_0_i,
    input  logic [AW-1:0] waddr_0_i,
    input  logic [31:0]   wdata_0_i,
    input  logic          we_1_i,
    input  logic [AW-1:0] waddr_1_i,
    input  logic [31:0]   wdata_1_i,
    input  logic          we_2_i,
    input  logic [AW-1:0] waddr_2_i,
    input  logic [31:0]   wdata_2_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [31:0]   rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [31:0]   rdata_b_o
);

    logic [31:0] mem [NUM_REGS];

    // NOTE: the storage array has no reset; the controller's valid flag says when its contents mean anything.
    always_ff @(posedge clk_i) begin
        if (we_0_i) mem[waddr_0_i] <= wdata_0_i;
        if (we_1_i) mem[waddr_1_i] <= wdata_1_i;
        if (we_2_i) mem[waddr_2_i] <= wdata_2_i;
    end

    assign rdata_a_o = mem[raddr_a_i];
    assign rdata_b_o = mem[raddr_b_i];

endmodule

// File: rtl/cv32e40p_rf_recovery_ctrl.sv
// Register-file recovery sequencer: snapshots the RF three registers per cycle and
// writes the snapshot back two registers per cycle, x0 excluded.
module cv32e40p_rf_recovery_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        backup_req_i,
    input  logic        recover_req_i,
    output logic        busy_o,
    output logic        snapshot_valid_o,
    output logic        done_o,
    output logic        error_o,
    output logic        regfile_backup_o,
    output logic [5:0]  regfile_raddr_ra_o,
    output logic [5:0]  regfile_raddr_rb_o,
    output logic [5:0]  regfile_raddr_rc_o,
    input  logic [31:0] regfile_rdata_ra_i,
    input  logic [31:0] regfile_rdata_rb_i,
    input  logic [31:0] regfile_rdata_rc_i,
    output logic        recover_o,
    output logic        regfile_we_a_o,
    output logic [5:0]  regfile_waddr_a_o,
    output logic [31:0] regfile_wdata_a_o,
    output logic        regfile_we_b_o,
    output logic [5:0]  regfile_waddr_b_o,
    output logic [31:0] regfile_wdata_b_o
);

    localparam int         AW           = $clog2(NUM_REGS);
    localparam logic [4:0] BACKUP_LAST  = 5'(rf_rec_ceil_div(NUM_REGS, RF_REC_RD_PORTS) - 1);
    localparam logic [4:0] RESTORE_LAST = 5'(rf_rec_ceil_div(NUM_REGS - 1, RF_REC_WR_PORTS) - 1);
    localparam logic [6:0] REG_LIMIT    = 7'(NUM_REGS);

    rf_rec_state_e state_q, state_d;
    logic [4:0]    k_q, k_d;
    logic          valid_q, valid_d;
    logic          error_q, error_d;
    logic          in_backup, in_restore, last_step;
    logic [6:0]    rd_addr_a, rd_addr_b, rd_addr_c;
    logic [6:0]    wr_addr_a, wr_addr_b;
    logic          rd_en_a, rd_en_b, rd_en_c;
    logic [31:0]   shadow_a, shadow_b;

    assign in_backup  = (state_q == BACKUP);
    assign in_restore = (state_q == RESTORE);
    assign last_step  = (in_backup && k_q == BACKUP_LAST) || (in_restore && k_q == RESTORE_LAST);

    // Full-width addresses decide the enables; only the low 6 bits leave the block.
    assign rd_addr_a = 7'(k_q) * 7'd3;
    assign rd_addr_b = rd_addr_a + 7'd1;
    assign rd_addr_c = rd_addr_a + 7'd2;
    assign wr_addr_a = {1'b0, k_q, 1'b1};
    assign wr_addr_b = {1'b0, k_q, 1'b0} + 7'd2;

    assign rd_en_a = in_backup && (rd_addr_a < REG_LIMIT);
    assign rd_en_b = in_backup && (rd_addr_b < REG_LIMIT);
    assign rd_en_c = in_backup && (rd_addr_c < REG_LIMIT);

    cv32e40p_rf_recovery_shadow #(
        .NUM_REGS (NUM_REGS)
    ) u_shadow (
        .clk_i     (clk_i),
        .we_0_i    (rd_en_a),
        .waddr_0_i (rd_addr_a[AW-1:0]),
        .wdata_0_i (regfile_rdata_ra_i),
        .we_1_i    (rd_en_b),
        .waddr_1_i (rd_addr_b[AW-1:0]),
        .wdata_1_i (regfile_rdata_rb_i),
        .we_2_i    (rd_en_c),
        .waddr_2_i (rd_addr_c[AW-1:0]),
        .wdata_2_i (regfile_rdata_rc_i),
        .raddr_a_i (wr_addr_a[AW-1:0]),
        .rdata_a_o (shadow_a),
        .raddr_b_i (wr_addr_b[AW-1:0]),
        .rdata_b_o (shadow_b)
    );

    // NOTE: sequential state is updated only with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            valid_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            valid_q <= valid_d;
            error_q <= error_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        k_d     = k_q + 5'd1;
        valid_d = valid_q;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                k_d = '0;
                if (recover_req_i) begin
                    if (valid_q) state_d = RESTORE;
                    else         error_d = 1'b1;
                end else if (backup_req_i) begin
                    valid_d = 1'b0;
                    state_d = BACKUP;
                end
            end
            BACKUP: begin
                if (last_step) begin
                    state_d = IDLE;
                    k_d     = '0;
                    valid_d = 1'b1;
                end
            end
            RESTORE: begin
                if (last_step) begin
                    state_d = IDLE;
                    k_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                k_d     = '0;
            end
        endcase
    end

    assign busy_o           = in_backup || in_restore;
    assign snapshot_valid_o = valid_q;
    assign done_o           = last_step;
    assign error_o          = error_q;

    assign regfile_backup_o   = in_backup;
    assign regfile_raddr_ra_o = in_backup ? rd_addr_a[5:0] : 6'd0;
    assign regfile_raddr_rb_o = in_backup ? rd_addr_b[5:0] : 6'd0;
    assign regfile_raddr_rc_o = in_backup ? rd_addr_c[5:0] : 6'd0;

    // Write enables drop in the very cycle reset is raised, ahead of the state change.
    assign recover_o         = in_restore;
    assign regfile_we_a_o    = in_restore && !rst_i && (wr_addr_a < REG_LIMIT);
    assign regfile_we_b_o    = in_restore && !rst_i && (wr_addr_b < REG_LIMIT);
    assign regfile_waddr_a_o = in_restore ? wr_addr_a[5:0] : 6'd0;
    assign regfile_waddr_b_o = in_restore ? wr_addr_b[5:0] : 6'd0;
    assign regfile_wdata_a_o = regfile_we_a_o ? shadow_a : 32'd0;
    assign regfile_wdata_b_o = regfile_we_b_o ? shadow_b : 32'd0;

endmodule

// File: tb/tb_cv32e40p_rf_recovery_ctrl.sv
// Directed bench for the recovery sequencer: a 32-register instance for the main scenarios
// and a 64-register instance for the wider address range.
module tb_cv32e40p_rf_recovery_ctrl;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    // ---------------- 32-register instance ----------------
    logic        bk_32, rc_32;
    logic        busy_32, valid_32, done_32, err_32, rfb_32, rec_32;
    logic [5:0]  ra_32, rb_32, rcad_32, wa_32, wb_32;
    logic [31:0] da_32, db_32, dc_32, wda_32, wdb_32;
    logic        wea_32, web_32;
    logic [31:0] rf32 [32];

    always_comb begin
        da_32 = (ra_32   < 6'd32) ? rf32[ra_32[4:0]]   : 32'hDEADBEEF;
        db_32 = (rb_32   < 6'd32) ? rf32[rb_32[4:0]]   : 32'hDEADBEEF;
        dc_32 = (rcad_32 < 6'd32) ? rf32[rcad_32[4:0]] : 32'hDEADBEEF;
    end

    cv32e40p_rf_recovery_ctrl #(.NUM_REGS(32)) dut32 (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .backup_req_i       (bk_32),
        .recover_req_i      (rc_32),
        .busy_o             (busy_32),
        .snapshot_valid_o   (valid_32),
        .done_o             (done_32),
        .error_o            (err_32),
        .regfile_backup_o   (rfb_32),
        .regfile_raddr_ra_o (ra_32),
        .regfile_raddr_rb_o (rb_32),
        .regfile_raddr_rc_o (rcad_32),
        .regfile_rdata_ra_i (da_32),
        .regfile_rdata_rb_i (db_32),
        .regfile_rdata_rc_i (dc_32),
        .recover_o          (rec_32),
        .regfile_we_a_o     (wea_32),
        .regfile_waddr_a_o  (wa_32),
        .regfile_wdata_a_o  (wda_32),
        .regfile_we_b_o     (web_32),
        .regfile_waddr_b_o  (wb_32),
        .regfile_wdata_b_o  (wdb_32)
    );

    // ---------------- 64-register instance ----------------
    logic        bk_64, rc_64;
    logic        busy_64, valid_64, done_64, err_64, rfb_64, rec_64;
    logic [5:0]  ra_64, rb_64, rcad_64, wa_64, wb_64;
    logic [31:0] da_64, db_64, dc_64, wda_64, wdb_64;
    logic        wea_64, web_64;
    logic [31:0] rf64 [64];

    always_comb begin
        da_64 = rf64[ra_64];
        db_64 = rf64[rb_64];
        dc_64 = rf64[rcad_64];
    end

    cv32e40p_rf_recovery_ctrl #(.NUM_REGS(64)) dut64 (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .backup_req_i       (bk_64),
        .recover_req_i      (rc_64),
        .busy_o             (busy_64),
        .snapshot_valid_o   (valid_64),
        .done_o             (done_64),
        .error_o            (err_64),
        .regfile_backup_o   (rfb_64),
        .regfile_raddr_ra_o (ra_64),
        .regfile_raddr_rb_o (rb_64),
        .regfile_raddr_rc_o (rcad_64),
        .regfile_rdata_ra_i (da_64),
        .regfile_rdata_rb_i (db_64),
        .regfile_rdata_rc_i (dc_64),
        .recover_o          (rec_64),
        .regfile_we_a_o     (wea_64),
        .regfile_waddr_a_o  (wa_64),
        .regfile_wdata_a_o  (wda_64),
        .regfile_we_b_o     (web_64),
        .regfile_waddr_b_o  (wb_64),
        .regfile_wdata_b_o  (wdb_64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are sampled and inputs changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        bk_32 = 1'b0; rc_32 = 1'b0;
        bk_64 = 1'b0; rc_64 = 1'b0;
        for (int i = 0; i < 32; i++) rf32[i] = (i == 0) ? 32'd0 : 32'hA5A50000 + 32'(i);
        for (int i = 0; i < 64; i++) rf64[i] = (i == 0) ? 32'd0 : 32'hC0DE0000 + 32'(i);
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check("rst_busy",   32'(busy_32),  32'd0);
        check("rst_valid",  32'(valid_32), 32'd0);
        check("rst_done",   32'(done_32),  32'd0);
        check("rst_error",  32'(err_32),   32'd0);
        check("rst_backup", 32'(rfb_32),   32'd0);
        check("rst_we_a",   32'(wea_32),   32'd0);
        check("rst_ra",     32'(ra_32),    32'd0);

        // Recover without a snapshot: one registered error pulse, no activity
        rc_32 = 1'b1;
        tick();
        rc_32 = 1'b0;
        check("noval_err",  32'(err_32),  32'd1);
        check("noval_busy", 32'(busy_32), 32'd0);
        check("noval_we_a", 32'(wea_32),  32'd0);
        check("noval_rec",  32'(rec_32),  32'd0);
        tick();
        check("noval_err_end", 32'(err_32), 32'd0);

        // Full backup: 11 busy cycles, addresses 3k/3k+1/3k+2, done on k=10
        bk_32 = 1'b1;
        tick();
        bk_32 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            check($sformatf("bk_busy[%0d]", c), 32'(busy_32), 32'd1);
            check($sformatf("bk_rfb[%0d]", c),  32'(rfb_32),  32'd1);
            check($sformatf("bk_ra[%0d]", c),   32'(ra_32),   32'(3 * c));
            check($sformatf("bk_rb[%0d]", c),   32'(rb_32),   32'(3 * c + 1));
            check($sformatf("bk_rc[%0d]", c),   32'(rcad_32), 32'(3 * c + 2));
            check($sformatf("bk_done[%0d]", c), 32'(done_32), (c == 10) ? 32'd1 : 32'd0);
            check($sformatf("bk_valid[%0d]", c), 32'(valid_32), 32'd0);
            tick();
        end
        check("bk_end_busy",  32'(busy_32),  32'd0);
        check("bk_end_valid", 32'(valid_32), 32'd1);
        check("bk_end_ra",    32'(ra_32),    32'd0);

        // Overwrite the RF; restore must replay the snapshot
        for (int i = 1; i < 32; i++) rf32[i] = 32'h11110000 + 32'(i);
        rc_32 = 1'b1;
        tick();
        rc_32 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check($sformatf("rs_rec[%0d]", c),  32'(rec_32), 32'd1);
            check($sformatf("rs_wea[%0d]", c),  32'(wea_32), 32'd1);
            check($sformatf("rs_wa[%0d]", c),   32'(wa_32),  32'(2 * c + 1));
            check($sformatf("rs_wda[%0d]", c),  wda_32,      32'hA5A50000 + 32'(2 * c + 1));
            check($sformatf("rs_web[%0d]", c),  32'(web_32), (c < 15) ? 32'd1 : 32'd0);
            if (c < 15) begin
                check($sformatf("rs_wb[%0d]", c),  32'(wb_32), 32'(2 * c + 2));
                check($sformatf("rs_wdb[%0d]", c), wdb_32,     32'hA5A50000 + 32'(2 * c + 2));
            end
            check($sformatf("rs_done[%0d]", c), 32'(done_32), (c == 15) ? 32'd1 : 32'd0);
            tick();
        end
        check("rs_end_busy",  32'(busy_32),  32'd0);
        check("rs_end_valid", 32'(valid_32), 32'd1);
        check("rs_end_we_a",  32'(wea_32),   32'd0);

        // Both requests together with a valid snapshot: restore wins, snapshot stays valid
        bk_32 = 1'b1;
        rc_32 = 1'b1;
        tick();
        bk_32 = 1'b0;
        rc_32 = 1'b0;
        check("both_rec",   32'(rec_32),   32'd1);
        check("both_rfb",   32'(rfb_32),   32'd0);
        check("both_valid", 32'(valid_32), 32'd1);
        repeat (15) tick();
        check("both_done", 32'(done_32), 32'd1);
        tick();
        check("both_end_busy",  32'(busy_32),  32'd0);
        check("both_end_valid", 32'(valid_32), 32'd1);

        // Reset at backup step 5: partial snapshot discarded
        bk_32 = 1'b1;
        tick();
        bk_32 = 1'b0;
        repeat (5) tick();
        check("rstbk_ra5", 32'(ra_32), 32'd15);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("rstbk_busy",  32'(busy_32),  32'd0);
        check("rstbk_valid", 32'(valid_32), 32'd0);
        rc_32 = 1'b1;
        tick();
        rc_32 = 1'b0;
        check("rstbk_err",  32'(err_32),  32'd1);
        check("rstbk_busy2", 32'(busy_32), 32'd0);

        // Recover pulsed during backup is ignored; backup still takes 11 cycles
        bk_32 = 1'b1;
        tick();
        bk_32 = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c == 3) rc_32 = 1'b1;
            if (c == 4) rc_32 = 1'b0;
            check($sformatf("ign_rfb[%0d]", c),  32'(rfb_32),  32'd1);
            check($sformatf("ign_rec[%0d]", c),  32'(rec_32),  32'd0);
            check($sformatf("ign_err[%0d]", c),  32'(err_32),  32'd0);
            check($sformatf("ign_done[%0d]", c), 32'(done_32), (c == 10) ? 32'd1 : 32'd0);
            tick();
        end
        check("ign_end_busy",  32'(busy_32),  32'd0);
        check("ign_end_valid", 32'(valid_32), 32'd1);

        // Reset during restore: write enables drop in the same cycle
        rc_32 = 1'b1;
        tick();
        rc_32 = 1'b0;
        repeat (3) tick();
        check("rstrs_we_pre", 32'(wea_32), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rstrs_we_a", 32'(wea_32), 32'd0);
        check("rstrs_we_b", 32'(web_32), 32'd0);
        tick();
        rst_i = 1'b0;
        check("rstrs_busy",  32'(busy_32),  32'd0);
        check("rstrs_valid", 32'(valid_32), 32'd0);

        // 64 registers: 22-cycle backup ending at 63/64/65 (64 and 65 wrap to 0 and 1 in 6 bits)
        bk_64 = 1'b1;
        tick();
        bk_64 = 1'b0;
        for (int c = 0; c < 22; c++) begin
            check($sformatf("b64_busy[%0d]", c), 32'(busy_64), 32'd1);
            check($sformatf("b64_done[%0d]", c), 32'(done_64), (c == 21) ? 32'd1 : 32'd0);
            if (c == 21) begin
                check("b64_ra_last", 32'(ra_64),   32'd63);
                check("b64_rb_last", 32'(rb_64),   32'd0);
                check("b64_rc_last", 32'(rcad_64), 32'd1);
            end
            tick();
        end
        check("b64_end_busy",  32'(busy_64),  32'd0);
        check("b64_end_valid", 32'(valid_64), 32'd1);

        // 64 registers: 32-cycle restore; out-of-range backup reads must not have hit x1/x0
        for (int i = 1; i < 64; i++) rf64[i] = 32'h22220000 + 32'(i);
        rc_64 = 1'b1;
        tick();
        rc_64 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            check($sformatf("r64_wea[%0d]", c), 32'(wea_64), 32'd1);
            check($sformatf("r64_wa[%0d]", c),  32'(wa_64),  32'(2 * c + 1));
            check($sformatf("r64_wda[%0d]", c), wda_64,      32'hC0DE0000 + 32'(2 * c + 1));
            check($sformatf("r64_web[%0d]", c), 32'(web_64), (c < 31) ? 32'd1 : 32'd0);
            if (c < 31)
                check($sformatf("r64_wdb[%0d]", c), wdb_64, 32'hC0DE0000 + 32'(2 * c + 2));
            check($sformatf("r64_done[%0d]", c), 32'(done_64), (c == 31) ? 32'd1 : 32'd0);
            tick();
        end
        check("r64_end_busy",  32'(busy_64),  32'd0);
        check("r64_end_valid", 32'(valid_64), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
